pin_pair_packer: RTL

//   Downstream consumer of the 2-bit dual-DFF capture stage (data_out[1:0]).

---
 rtl/pin_packer_pkg.sv | 18 +
 rtl/pin_packer_fifo.sv | 66 ++++++
 rtl/pin_pair_packer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pin_packer_pkg.sv
// Shared types and helpers for the 2-bit sample packer.
// The top's out_parity port and parity storage exist only when PIN_PACKER_PARITY_EN is defined.
package pin_packer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int DEF_WORD_W   = 8;
    localparam int SAMPLES      = DEF_WORD_W / 2;
    localparam int SAMPLE_IDX_W = $clog2(SAMPLES);

    function automatic int samples_of(input int word_w);
        return word_w / 2;
    endfunction

endpackage

// File: rtl/pin_packer_fifo.sv
// Show-ahead synchronous FIFO with a registered head word.
// Pointers carry an extra MSB so full and empty can be told apart.
module pin_packer_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr_q, rptr_q, wptr_d, rptr_d;
    logic [DW-1:0] dout_q, head_d;
    logic          empty_q;
    logic          do_pop, do_push;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty_q;
    assign do_push = push && (!full || do_pop);
    assign wptr_d  = wptr_q + (AW+1)'(do_push);
    assign rptr_d  = rptr_q + (AW+1)'(do_pop);

    // The new head is the incoming word when it lands in the head slot this cycle.
    always_comb begin
        head_d = dout_q;
        if (rptr_d != wptr_d) begin
            if (do_push && (rptr_d == wptr_q)) begin
                head_d = din;
            end else begin
                head_d = mem[rptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            dout_q  <= '0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            dout_q  <= head_d;
            empty_q <= (rptr_d == wptr_d);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= din;
        end
    end

    assign empty = empty_q;
    assign dout  = dout_q;

endmodule

// File: rtl/pin_pair_packer.sv
// Packs 2-bit capture samples LSB-first into words and queues them behind a valid/ready port.
// Optional feature: PIN_PACKER_PARITY_EN adds out_parity (even parity of out_data).
//
// state | meaning
// IDLE  | no partial word; sample index 0
// FILL  | partial word pending in the shift register
module pin_pair_packer
    import pin_packer_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  ovf_count,
    output logic              busy
`ifdef PIN_PACKER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int N_SMP = samples_of(WORD_W);
    localparam int IDX_W = $clog2(N_SMP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SMP - 1);

`ifdef PIN_PACKER_PARITY_EN
    localparam int FIFO_W = WORD_W + 1;
`else
    localparam int FIFO_W = WORD_W;
`endif

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d, packed_word;
    logic [CNT_W-1:0]  ovf_q;
    logic              push;
    logic              fifo_full, fifo_empty;
    logic              pop_xfer;
    logic [FIFO_W-1:0] fifo_din, fifo_dout;

    always_comb begin
        packed_word = word_q;
        if (in_valid) begin
            for (int k = 0; k < N_SMP; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    packed_word[2*k +: 2] = in_data;
                end
            end
        end
    end

    // A sample arriving with flush is packed first, so both paths push packed_word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (flush) begin
                        push = 1'b1;
                    end else begin
                        state_d = FILL;
                        word_d  = packed_word;
                        idx_d   = IDX_W'(1);
                    end
                end
            end
            FILL: begin
                if ((in_valid && (idx_q == LAST_IDX)) || flush) begin
                    push    = 1'b1;
                    state_d = IDLE;
                    word_d  = '0;
                    idx_d   = '0;
                end else if (in_valid) begin
                    word_d = packed_word;
                    idx_d  = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                word_d  = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    assign pop_xfer = out_ready && !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (push && fifo_full && !pop_xfer && (ovf_q != {CNT_W{1'b1}})) begin
            ovf_q <= ovf_q + CNT_W'(1);
        end
    end

`ifdef PIN_PACKER_PARITY_EN
    assign fifo_din   = {^packed_word, packed_word};
    assign out_data   = fifo_dout[WORD_W-1:0];
    assign out_parity = fifo_dout[WORD_W];
`else
    assign fifo_din   = packed_word;
    assign out_data   = fifo_dout;
`endif

    pin_packer_fifo #(
        .DW    (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (out_ready),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    assign out_valid = !fifo_empty;
    assign ovf_count = ovf_q;
    assign busy      = (state_q == FILL);

endmodule
